matc_block_writer: RTL

- Output-side writer for the systolic matrix-multiply datapath.
- Accepts completed BLOCK_SIZE x BLOCK_SIZE result blocks of matrix C over a valid/ready handshake.
- Writes each block into the output BRAM (port A) as row-major words, one block row per cycle.
- It is the write-side counterpart of the BRAM read/address controller that feeds the systolic core. Blocks arrive column-block first, then row-block, which matches the core's output order.

---
 rtl/matc_pkg.sv | 45 ++++
 rtl/matc_addr_gen.sv | 86 ++++++++
 rtl/matc_block_writer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/matc_pkg.sv
// -----------------------------------------------------------------------------
// matc_pkg
// Shared definitions for the matrix-C block writer:
//   - state_t       : writer FSM state encoding
//   - row_size_c    : number of block rows in matrix C
//   - col_size_c    : number of block columns in matrix C
//   - max_flag_c    : number of blocks in matrix C
//   - blk_row_addr  : BRAM word address of one row of one block
// -----------------------------------------------------------------------------
package matc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE,
        DONE
    } state_t;

    function automatic int unsigned row_size_c(input int unsigned i_outer,
                                               input int unsigned bs);
        return i_outer / bs;
    endfunction

    function automatic int unsigned col_size_c(input int unsigned w_outer,
                                               input int unsigned bs);
        return w_outer / bs;
    endfunction

    function automatic int unsigned max_flag_c(input int unsigned i_outer,
                                               input int unsigned w_outer,
                                               input int unsigned bs);
        return row_size_c(i_outer, bs) * col_size_c(w_outer, bs);
    endfunction

    // Row-major word address: each word holds one block row (bs elements),
    // so a matrix row spans cols words.
    function automatic int unsigned blk_row_addr(input int unsigned br,
                                                 input int unsigned bc,
                                                 input int unsigned r,
                                                 input int unsigned bs,
                                                 input int unsigned cols);
        return (br * bs + r) * cols + bc;
    endfunction

endpackage

// File: rtl/matc_addr_gen.sv
// -----------------------------------------------------------------------------
// matc_addr_gen
// Block/row counters and BRAM address generation for matc_block_writer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : zero all counters (new matrix armed)
//   row_start   : a block is accepted; next row emitted is row 0
//   row_step    : a non-final row was emitted; advance row counter
//   blk_step    : final row of a block emitted; advance bc/br/blk_cnt
//   row_idx     : index of the next row to be emitted
//   addr        : BRAM address of that row
//   row_last    : current row is the last row of the block
//   blk_last    : current block is the last block of the matrix
// -----------------------------------------------------------------------------
module matc_addr_gen
    import matc_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE        = 2,
    parameter int unsigned I_OUTER_DIMENSION = 6,
    parameter int unsigned W_OUTER_DIMENSION = 6,
    parameter int unsigned ADDR_WIDTH        = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic                               row_start,
    input  logic                               row_step,
    input  logic                               blk_step,
    output logic [$clog2(BLOCK_SIZE+1)-1:0]    row_idx,
    output logic [ADDR_WIDTH-1:0]              addr,
    output logic                               row_last,
    output logic                               blk_last
);

    localparam int unsigned ROW_SIZE_MAT_C = row_size_c(I_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned COL_SIZE_MAT_C = col_size_c(W_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned MAX_FLAG       = max_flag_c(I_OUTER_DIMENSION, W_OUTER_DIMENSION, BLOCK_SIZE);

    localparam int unsigned RW  = $clog2(BLOCK_SIZE + 1);
    localparam int unsigned CW  = $clog2(COL_SIZE_MAT_C + 1);
    localparam int unsigned BRW = $clog2(ROW_SIZE_MAT_C + 1);
    localparam int unsigned BKW = $clog2(MAX_FLAG + 1);

    logic [RW-1:0]  row_q;
    logic [CW-1:0]  bc_q;
    logic [BRW-1:0] br_q;
    logic [BKW-1:0] blk_cnt;

    // The address is needed one cycle ahead of the registered output, so it is
    // computed for the row about to be emitted rather than the current one.
    assign row_idx  = row_start ? '0 : row_q + RW'(1);
    assign row_last = (row_q == RW'(BLOCK_SIZE - 1));
    assign blk_last = (blk_cnt == BKW'(MAX_FLAG - 1));
    assign addr     = ADDR_WIDTH'(blk_row_addr(32'(br_q), 32'(bc_q), 32'(row_idx),
                                               BLOCK_SIZE, COL_SIZE_MAT_C));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            bc_q    <= '0;
            br_q    <= '0;
            blk_cnt <= '0;
        end else if (clear) begin
            row_q   <= '0;
            bc_q    <= '0;
            br_q    <= '0;
            blk_cnt <= '0;
        end else begin
            if (row_start)
                row_q <= '0;
            else if (row_step)
                row_q <= row_q + RW'(1);

            if (blk_step) begin
                blk_cnt <= blk_cnt + BKW'(1);
                if (bc_q == CW'(COL_SIZE_MAT_C - 1)) begin
                    bc_q <= '0;
                    br_q <= (br_q == BRW'(ROW_SIZE_MAT_C - 1)) ? '0 : br_q + BRW'(1);
                end else begin
                    bc_q <= bc_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matc_block_writer.sv
// -----------------------------------------------------------------------------
// matc_block_writer
// Writes BLOCK_SIZE x BLOCK_SIZE result blocks of matrix C into the output
// BRAM (port A), one block row per cycle, row-major. Blocks arrive column-block
// first, then row-block.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse that arms a new matrix write (IDLE or DONE only)
//   in_valid   : result block present
//   in_ready   : writer can accept a block
//   in_data    : block, element (r,c) at [WIDTH*(r*BLOCK_SIZE+c) +: WIDTH]
//   out_en     : BRAM port enable
//   out_we     : BRAM write enable
//   out_addr   : BRAM word address
//   out_din    : one block row
//   busy       : matrix write in progress
//   done       : all blocks written; held until next start
//   checksum   : running XOR of written rows (only with
//                MATC_BLOCK_WRITER_CHECKSUM_EN defined)
// -----------------------------------------------------------------------------
module matc_block_writer
    import matc_pkg::*;
#(
    parameter int unsigned WIDTH             = 16,
    parameter int unsigned BLOCK_SIZE        = 2,
    parameter int unsigned I_OUTER_DIMENSION = 6,
    parameter int unsigned W_OUTER_DIMENSION = 6,
    parameter int unsigned ADDR_WIDTH        = 12
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]   in_data,
    output logic                                     out_en,
    output logic                                     out_we,
    output logic [ADDR_WIDTH-1:0]                    out_addr,
    output logic [WIDTH*BLOCK_SIZE-1:0]              out_din,
    output logic                                     busy,
    output logic                                     done
`ifdef MATC_BLOCK_WRITER_CHECKSUM_EN
    ,
    output logic [WIDTH*BLOCK_SIZE-1:0]              checksum
`endif
);

    localparam int unsigned ROW_BITS = WIDTH * BLOCK_SIZE;
    localparam int unsigned BLK_BITS = ROW_BITS * BLOCK_SIZE;
    localparam int unsigned RW       = $clog2(BLOCK_SIZE + 1);

    state_t              state;
    logic [BLK_BITS-1:0] blk_q;
    logic [BLK_BITS-1:0] row_src;
    logic [ROW_BITS-1:0] row_nxt;
    logic [RW-1:0]       row_idx;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                accept;
    logic                arm;
    logic                row_last;
    logic                blk_last;
    logic                row_step;
    logic                blk_step;

    assign accept   = (state == RUN) && in_valid && in_ready;
    assign arm      = start && ((state == IDLE) || (state == DONE));
    assign row_step = (state == WRITE) && !row_last;
    assign blk_step = (state == WRITE) && row_last;

    // Row 0 is emitted straight from in_data on the accept edge, so the block
    // register is bypassed for that row.
    assign row_src = accept ? in_data : blk_q;

    always_comb begin
        row_nxt = '0;
        for (int unsigned r = 0; r < BLOCK_SIZE; r++) begin
            if (row_idx == RW'(r))
                row_nxt = row_src[r*ROW_BITS +: ROW_BITS];
        end
    end

    matc_addr_gen #(
        .BLOCK_SIZE        (BLOCK_SIZE),
        .I_OUTER_DIMENSION (I_OUTER_DIMENSION),
        .W_OUTER_DIMENSION (W_OUTER_DIMENSION),
        .ADDR_WIDTH        (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (arm),
        .row_start (accept),
        .row_step  (row_step),
        .blk_step  (blk_step),
        .row_idx   (row_idx),
        .addr      (addr_nxt),
        .row_last  (row_last),
        .blk_last  (blk_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            blk_q    <= '0;
            in_ready <= 1'b0;
            out_en   <= 1'b0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        state    <= WRITE;
                        blk_q    <= in_data;
                        in_ready <= 1'b0;
                        out_en   <= 1'b1;
                        out_we   <= 1'b1;
                        out_addr <= addr_nxt;
                        out_din  <= row_nxt;
                    end
                end
                WRITE: begin
                    if (row_last) begin
                        out_en <= 1'b0;
                        out_we <= 1'b0;
                        if (blk_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        out_addr <= addr_nxt;
                        out_din  <= row_nxt;
                    end
                end
                DONE: begin
                    if (arm) begin
                        state    <= RUN;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATC_BLOCK_WRITER_CHECKSUM_EN
    // Folds in each row on the same edge that loads it into out_din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum <= '0;
        else if (arm)
            checksum <= '0;
        else if (accept || row_step)
            checksum <= checksum ^ row_nxt;
    end
`endif

endmodule
